// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared state encoding and default reset-vector address
package pc_fetch_pkg;
  typedef enum logic [1:0] {ST_RST, ST_VEC_LO, ST_VEC_HI, ST_RUN} state_t;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;
endpackage

// File: rtl/pc_fetch_pcl.sv
// pcl: program-counter low byte with load, increment and carry-out
module pcl (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ld,
  input  logic [7:0] i_ld_val,
  input  logic       i_inc,
  output logic [7:0] o_pcl,
  output logic       o_carry
);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) o_pcl <= 8'h00;
    else if (i_ld) o_pcl <= i_ld_val;
    else if (i_inc) o_pcl <= o_pcl + 8'h01;
  assign o_carry = i_inc && o_pcl == 8'hFF;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: reset-vector load and PC sequencing with byte fetch
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rdy,
  input  logic [7:0]  i_data,
  input  logic        i_inc,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  input  logic [7:0]  i_pch,
  output logic [15:0] o_addr,
  output logic [7:0]  o_pcl,
  output logic        o_pch_pch,
  output logic        o_adh_pch,
  output logic        o_pclc,
  output logic [7:0]  o_adh,
  output logic        o_fetch_valid,
  output logic [7:0]  o_fetch_data,
  output logic        o_running
);
  state_t     state, state_nxt;
  logic       ld, inc;
  logic [7:0] ld_val;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= ST_RST;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_val    = i_data;
    inc       = 1'b0;
    o_addr    = RESET_VECTOR;
    o_pch_pch = 1'b1;
    o_adh_pch = 1'b0;
    o_adh     = 8'h00;
    case (state)
      ST_RST: state_nxt = ST_VEC_LO;
      ST_VEC_LO: begin
        ld        = i_rdy;
        state_nxt = i_rdy ? ST_VEC_HI : ST_VEC_LO;
      end
      ST_VEC_HI: begin
        o_addr    = RESET_VECTOR + 16'd1;
        o_adh_pch = i_rdy;
        o_pch_pch = !i_rdy;
        o_adh     = i_rdy ? i_data : 8'h00;
        state_nxt = i_rdy ? ST_RUN : ST_VEC_HI;
      end
      ST_RUN: begin
        o_addr    = {i_pch, o_pcl};
        ld        = i_rdy && i_jump;
        ld_val    = i_jump_addr[7:0];
        inc       = i_rdy && !i_jump && i_inc;
        o_adh_pch = ld;
        o_pch_pch = !ld;
        o_adh     = ld ? i_jump_addr[15:8] : 8'h00;
      end
    endcase
  end
  pcl u_pcl (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ld      (ld),
    .i_ld_val  (ld_val),
    .i_inc     (inc),
    .o_pcl     (o_pcl),
    .o_carry   (o_pclc)
  );
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_fetch_valid <= 1'b0;
      o_fetch_data  <= 8'h00;
    end else begin
      o_fetch_valid <= inc;
      if (inc) o_fetch_data <= i_data;
    end
  assign o_running = state == ST_RUN;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized scoreboard bench for pc_fetch against a 16-bit PC model
module tb_pc_fetch;
  localparam logic [15:0] RV = 16'hFFFC;
  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_rdy = 1'b0, i_inc = 1'b0, i_jump = 1'b0;
  logic [15:0] i_jump_addr = 16'h0000;
  logic [7:0]  i_data, i_pch = 8'h00;
  logic [15:0] o_addr;
  logic [7:0]  o_pcl, o_adh, o_fetch_data;
  logic        o_pch_pch, o_adh_pch, o_pclc, o_fetch_valid, o_running;
  logic [7:0]  mem [0:65535];
  logic [7:0]  q [$];
  logic [15:0] m_pc;
  int          phase;
  int          checks = 0, passes = 0;

  pc_fetch #(.RESET_VECTOR(RV)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rdy(i_rdy), .i_data(i_data),
    .i_inc(i_inc), .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_pch(i_pch),
    .o_addr(o_addr), .o_pcl(o_pcl), .o_pch_pch(o_pch_pch), .o_adh_pch(o_adh_pch),
    .o_pclc(o_pclc), .o_adh(o_adh), .o_fetch_valid(o_fetch_valid),
    .o_fetch_data(o_fetch_data), .o_running(o_running)
  );

  always #5 i_clk = ~i_clk;
  assign i_data = mem[o_addr];
  always @(posedge i_clk) i_pch <= o_adh_pch ? o_adh : i_pch + {7'b0, o_pclc};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge i_clk)
    if (i_reset_n) begin
      chk("fetch_valid", {31'b0, o_fetch_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) chk("fetch_data", {24'b0, o_fetch_data}, {24'b0, q.pop_front()});
    end

  task automatic step(input logic r, input logic inc, input logic j, input logic [15:0] ja);
    @(negedge i_clk);
    i_rdy = r; i_inc = inc; i_jump = j; i_jump_addr = ja;
    #1;
    chk("addr", {16'b0, o_addr}, {16'b0, phase == 3 ? m_pc : phase == 2 ? RV + 16'd1 : RV});
    chk("running", {31'b0, o_running}, {31'b0, phase == 3});
    chk("pclc", {31'b0, o_pclc}, {31'b0, phase == 3 && r && !j && inc && m_pc[7:0] == 8'hFF});
    chk("ctl_excl", {31'b0, o_pch_pch & o_adh_pch}, 32'd0);
    chk("adh_idle", {24'b0, o_adh_pch ? 8'h00 : o_adh}, 32'd0);
    if (phase == 3) chk("pcl", {24'b0, o_pcl}, {24'b0, m_pc[7:0]});
    if (phase == 3) begin
      if (r && j) m_pc = ja;
      else if (r && inc) begin
        q.push_back(mem[m_pc]);
        m_pc = m_pc + 16'd1;
      end
    end else if (phase == 2 && r) begin
      phase = 3;
      m_pc = {mem[RV + 16'd1], mem[RV]};
    end else if (phase == 1 && r) phase = 2;
  endtask

  task automatic release_reset();
    @(negedge i_clk);
    i_rdy = 1'b1; i_inc = 1'b0; i_jump = 1'b0;
    i_reset_n = 1'b1;
    #1;
    chk("rst_addr", {16'b0, o_addr}, {16'b0, RV});
    chk("rst_running", {31'b0, o_running}, 32'd0);
    phase = 1;
  endtask

  task automatic async_reset_check();
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    q.delete();
    phase = 0;
    #1;
    chk("ar_running", {31'b0, o_running}, 32'd0);
    chk("ar_valid", {31'b0, o_fetch_valid}, 32'd0);
    chk("ar_data", {24'b0, o_fetch_data}, 32'd0);
    chk("ar_pcl", {24'b0, o_pcl}, 32'd0);
    repeat (2) @(posedge i_clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[RV] = 8'h34;
    mem[RV + 16'd1] = 8'h12;
    mem[16'h12FF] = 8'hA5;
    mem[16'hFFFF] = 8'h5C;
    phase = 0;
    m_pc = 16'h0000;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_running", {31'b0, o_running}, 32'd0);
    chk("reset_valid", {31'b0, o_fetch_valid}, 32'd0);
    chk("reset_pcl", {24'b0, o_pcl}, 32'd0);
    release_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("vec_addr", {16'b0, o_addr}, 32'h1234);
    step(1, 0, 1, 16'h12FF);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("carry_addr", {16'b0, o_addr}, 32'h1300);
    step(1, 0, 1, 16'hFFFF);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("wrap_addr", {16'b0, o_addr}, 32'h0000);
    step(1, 1, 1, 16'hC000);
    step(1, 0, 0, 0);
    chk("jump_addr", {16'b0, o_addr}, 32'hC000);
    repeat (3) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    async_reset_check();
    release_reset();
    repeat (3) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ja;
      ja = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ja[7:0] = 8'hF0 + 8'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 1, ja);
      if (n == 200) begin
        async_reset_check();
        release_reset();
      end
    end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'hFFFC; address of reset-vector low byte (high byte at RESET_VECTOR+1).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_rdy  input  1  memory ready; low = stall current cycle.
REQ-005 SHALL have port i_data  input  8  memory read data for the address on o_addr this cycle.
REQ-006 SHALL have port i_inc  input  1  request: consume byte at PC, advance PC by 1.
REQ-007 SHALL have port i_jump  input  1  request: load PC from i_jump_addr.
REQ-008 SHALL have port i_jump_addr  input  16  jump target.
REQ-009 SHALL have port i_pch  input  8  current PCH register value (from PCH block o_pch).
REQ-010 SHALL have port o_addr  output  16  memory address.
REQ-011 SHALL have port o_pcl  output  8  internal PC low register.
REQ-012 SHALL have ports o_pch_pch, o_adh_pch, o_pclc  output  1 each  PCH control signals (hold / load-from-ADH / carry-in).
REQ-013 SHALL have port o_adh  output  8  ADH value presented to PCH.
REQ-014 SHALL have port o_fetch_valid  output  1  one-cycle pulse: o_fetch_data holds a consumed byte.
REQ-015 SHALL have port o_fetch_data  output  8  last consumed byte.
REQ-016 SHALL have port o_running  output  1  high in state RUN.

Function
REQ-017 SHALL implement states RST, VEC_LO, VEC_HI, RUN.
REQ-018 RST: o_addr = RESET_VECTOR, o_pch_pch=1, o_adh_pch=0, o_pclc=0; next state VEC_LO unconditionally.
REQ-019 VEC_LO: o_addr = RESET_VECTOR; if i_rdy, PCL <= i_data, next VEC_HI; else hold.
REQ-020 VEC_HI: o_addr = RESET_VECTOR+1; if i_rdy: o_adh_pch=1, o_pch_pch=0, o_adh=i_data, o_pclc=0, next RUN; if !i_rdy: o_pch_pch=1, hold.
REQ-021 RUN: o_addr = {i_pch, PCL}; state stays RUN until reset.
REQ-022 RUN, i_rdy=0: all requests ignored; o_pch_pch=1, o_pclc=0, PCL unchanged, o_fetch_valid=0 next cycle.
REQ-023 RUN, i_rdy=1, i_jump=1: PCL <= i_jump_addr[7:0]; o_adh_pch=1, o_pch_pch=0, o_adh=i_jump_addr[15:8], o_pclc=0; i_inc ignored (jump priority).
REQ-024 RUN, i_rdy=1, i_inc=1, i_jump=0: PCL <= PCL+1 (8-bit wrap); o_pch_pch=1; o_pclc = (PCL==8'hFF), combinational same cycle; o_fetch_data <= i_data; o_fetch_valid=1 next cycle.
REQ-025 RUN, i_rdy=1, neither request: hold (o_pch_pch=1, o_pclc=0).
REQ-026 PC 16'hFFFF +1 SHALL wrap to 16'h0000 (PCL 00, PCH carry 00).
REQ-027 o_pch_pch and o_adh_pch SHALL never both be 1; o_adh = 8'h00 when o_adh_pch=0.
REQ-028 o_fetch_valid SHALL be 0 in all cycles not immediately following an accepted i_inc.
REQ-029 Latency: byte at PC visible on o_fetch_data one cycle after acceptance; new PC on o_addr one cycle after inc/jump.

Reset
REQ-030 Reset assertion SHALL immediately force: state RST, PCL=8'h00, o_fetch_valid=0, o_fetch_data=8'h00, o_running=0, regardless of clock.
REQ-031 Reset mid-operation (any state) SHALL abandon pending inc/jump; vector sequence restarts after deassertion.
REQ-032 PCH content before VEC_HI is undefined; o_addr in RUN SHALL only be relied upon after VEC_HI completes.

Structure
REQ-033 Shared package/header SHALL hold state encoding (2-bit) and default reset-vector constant 16'hFFFC.
REQ-034 PC low register with increment and carry-out SHALL be a sub-module named pcl; FSM and control decode in pc_fetch.

Verification
REQ-035 Reset, i_rdy=1, mem[FFFC]=34, mem[FFFD]=12 -> RUN on cycle 3, o_addr=1234.
REQ-036 PC=12FF, i_inc=1 -> o_pclc=1 same cycle; next o_addr=1300, o_fetch_valid pulse with mem[12FF].
REQ-037 PC=FFFF, i_inc=1 -> next o_addr=0000.
REQ-038 i_jump=1, i_inc=1, i_jump_addr=C000 -> next o_addr=C000, no o_fetch_valid.
REQ-039 i_rdy=0 for 3 cycles during VEC_LO and during RUN with i_inc=1 -> state/PC frozen, no fetch pulses, resume on i_rdy=1.
REQ-040 Reset asserted asynchronously mid-RUN -> outputs per REQ-030 without clock edge; vector refetched after release.
